// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state type, XADC aux-channel numbering, DRP address width and clog2 helper
package adc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT, ST_ACCUM} state_e;
    localparam int DRP_AW = 7;
    localparam logic [4:0] AUX0_CH = 5'h10;
    localparam logic [4:0] AUX6_CH = 5'h16;
    function automatic logic [4:0] aux_ch(input int n);
        return AUX0_CH + 5'(n);
    endfunction
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/adc_avg_lane.sv
// adc_avg_lane: per-lane boxcar accumulator, sample counter and result register
//   clk, reset_n : clock, async active-low reset
//   acc_en_i     : add sample_i this cycle (FSM in ACCUM for this lane)
//   sample_i     : MSB-aligned sample
//   done_o       : this addition completes a block of 2^AVG_LOG2 samples
//   avg_o        : average including sample_i (valid with done_o)
//   result_o     : last stored average
module adc_avg_lane #(
    parameter int ADC_BITS = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                acc_en_i,
    input  logic [ADC_BITS-1:0] sample_i,
    output logic                done_o,
    output logic [ADC_BITS-1:0] avg_o,
    output logic [ADC_BITS-1:0] result_o
);
    localparam int AW = ADC_BITS + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    logic [AW-1:0] acc_q, sum;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic [ADC_BITS-1:0] res_q;
    // AW bits hold 2^AVG_LOG2 full-scale samples without overflow
    assign sum = acc_q + AW'(sample_i);
    assign cnt_nx = cnt_q + 1'b1;
    assign done_o = acc_en_i && cnt_nx == CW'(2 ** AVG_LOG2);
    assign avg_o = ADC_BITS'(sum >> AVG_LOG2);
    assign result_o = res_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= done_o ? '0 : sum;
            cnt_q <= done_o ? '0 : cnt_nx;
            res_q <= done_o ? avg_o : res_q;
        end
    end
endmodule

// File: rtl/adc_multi_ch_avg.sv
// adc_multi_ch_avg: XADC EOC-driven DRP reader averaging NUM_CH consecutive channels
//   clk, reset_n        : clock (also XADC dclk), async active-low reset
//   eoc_in, channel_in  : XADC end-of-conversion and channel number
//   drp_den, drp_daddr  : DRP read request
//   drp_do, drp_drdy    : DRP read data / ready
//   sel_ch, sel_value   : registered display mux of lane results
//   ch_valid            : lanes that have produced at least one average
//   avg_stb/ch/value    : strobe and payload of each newly stored average
//   err_timeout/overrun : sticky error flags, cleared by err_clr
module adc_multi_ch_avg
    import adc_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter logic [4:0] CH_BASE      = AUX6_CH,
    parameter int         ADC_BITS     = 12,
    parameter int         AVG_LOG2     = 2,
    parameter int         DRDY_TIMEOUT = 31,
    localparam int        CH_W         = clog2(NUM_CH) > 1 ? clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                eoc_in,
    input  logic [4:0]          channel_in,
    output logic                drp_den,
    output logic [DRP_AW-1:0]   drp_daddr,
    input  logic [15:0]         drp_do,
    input  logic                drp_drdy,
    input  logic [CH_W-1:0]     sel_ch,
    output logic [ADC_BITS-1:0] sel_value,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic                avg_stb,
    output logic [CH_W-1:0]     avg_ch,
    output logic [ADC_BITS-1:0] avg_value,
    output logic                err_timeout,
    output logic                err_overrun,
    input  logic                err_clr
);
    localparam int TW = clog2(DRDY_TIMEOUT + 1);
    state_e state_q, state_d;
    logic eoc_q;
    logic [CH_W-1:0] lane_q, lane_d, avg_ch_q, avg_ch_d;
    logic [DRP_AW-1:0] daddr_q, daddr_d;
    logic [ADC_BITS-1:0] sample_q, sample_d, avg_value_q, avg_value_d, sel_value_q, sel_value_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic err_to_q, err_to_d, err_ov_q, err_ov_d, avg_stb_q, avg_stb_d;
    logic [NUM_CH-1:0] ch_valid_q, ch_valid_d, done;
    logic [ADC_BITS-1:0] lane_avg [NUM_CH];
    logic [ADC_BITS-1:0] lane_res [NUM_CH];
    logic [4:0] idx;
    logic valid_edge, to_set, ov_set;
    logic unused_drp_lsbs;
    // channels below CH_BASE wrap to large indices and fall out of range
    assign idx = channel_in - CH_BASE;
    assign valid_edge = eoc_in && !eoc_q && int'(idx) < NUM_CH;
    assign ov_set = valid_edge && state_q != ST_IDLE;
    assign unused_drp_lsbs = ^drp_do;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        adc_avg_lane #(.ADC_BITS(ADC_BITS), .AVG_LOG2(AVG_LOG2)) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .acc_en_i (state_q == ST_ACCUM && lane_q == CH_W'(i)),
            .sample_i (sample_q),
            .done_o   (done[i]),
            .avg_o    (lane_avg[i]),
            .result_o (lane_res[i])
        );
    end
    always_comb begin
        state_d = state_q;
        lane_d = lane_q;
        daddr_d = daddr_q;
        sample_d = sample_q;
        wcnt_d = wcnt_q;
        to_set = 1'b0;
        case (state_q)
            ST_IDLE: if (valid_edge) begin
                state_d = ST_READ;
                lane_d = CH_W'(idx);
                daddr_d = {2'b00, channel_in};
            end
            ST_READ: begin
                state_d = ST_WAIT;
                wcnt_d = '0;
            end
            ST_WAIT: if (drp_drdy) begin
                state_d = ST_ACCUM;
                sample_d = drp_do[15 -: ADC_BITS];
            end else if (wcnt_q == TW'(DRDY_TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                to_set = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // sel_value bypasses a result being written this cycle so it tracks avg_value
    always_comb begin
        avg_stb_d = |done;
        avg_ch_d = avg_ch_q;
        avg_value_d = avg_value_q;
        ch_valid_d = ch_valid_q;
        sel_value_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (done[k]) begin
                avg_ch_d = CH_W'(k);
                avg_value_d = lane_avg[k];
                ch_valid_d[k] = 1'b1;
            end
            if (sel_ch == CH_W'(k)) sel_value_d = done[k] ? lane_avg[k] : lane_res[k];
        end
        err_to_d = to_set || (err_to_q && !err_clr);
        err_ov_d = ov_set || (err_ov_q && !err_clr);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            eoc_q <= 1'b0;
            lane_q <= '0;
            daddr_q <= '0;
            sample_q <= '0;
            wcnt_q <= '0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
            avg_stb_q <= 1'b0;
            avg_ch_q <= '0;
            avg_value_q <= '0;
            sel_value_q <= '0;
            ch_valid_q <= '0;
        end else begin
            state_q <= state_d;
            eoc_q <= eoc_in;
            lane_q <= lane_d;
            daddr_q <= daddr_d;
            sample_q <= sample_d;
            wcnt_q <= wcnt_d;
            err_to_q <= err_to_d;
            err_ov_q <= err_ov_d;
            avg_stb_q <= avg_stb_d;
            avg_ch_q <= avg_ch_d;
            avg_value_q <= avg_value_d;
            sel_value_q <= sel_value_d;
            ch_valid_q <= ch_valid_d;
        end
    end
    assign drp_den = state_q == ST_READ;
    assign drp_daddr = daddr_q;
    assign sel_value = sel_value_q;
    assign ch_valid = ch_valid_q;
    assign avg_stb = avg_stb_q;
    assign avg_ch = avg_ch_q;
    assign avg_value = avg_value_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;
endmodule

// File: tb/tb_adc_multi_ch_avg.sv
// tb_adc_multi_ch_avg: directed scoreboard bench for adc_multi_ch_avg (default parameters)
module tb_adc_multi_ch_avg;
    logic clk = 0, reset_n = 0, eoc_in = 0, drp_drdy = 0, err_clr = 0;
    logic [4:0] channel_in = 0;
    logic [15:0] drp_do = 0;
    logic [1:0] sel_ch = 0;
    logic drp_den, avg_stb, err_timeout, err_overrun;
    logic [6:0] drp_daddr;
    logic [11:0] sel_value, avg_value;
    logic [3:0] ch_valid;
    logic [1:0] avg_ch;
    typedef struct {
        logic [1:0]  ch;
        logic [11:0] val;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int checks = 0, passes = 0, fails = 0, den_cnt;

    always #5 clk = ~clk;

    adc_multi_ch_avg dut (
        .clk(clk), .reset_n(reset_n), .eoc_in(eoc_in), .channel_in(channel_in),
        .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .sel_ch(sel_ch), .sel_value(sel_value), .ch_valid(ch_valid), .avg_stb(avg_stb),
        .avg_ch(avg_ch), .avg_value(avg_value), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every strobe must match the oldest expected average
    always @(negedge clk) if (reset_n && avg_stb) begin
        chk("stb_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("avg_ch", avg_ch, e.ch);
            chk("avg_value", avg_value, e.val);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eoc(input logic [4:0] ch);
        @(posedge clk); #1 channel_in = ch; eoc_in = 1;
        @(posedge clk); #1 eoc_in = 0;
    endtask

    task automatic wait_den(input logic [4:0] ch);
        int n = 0;
        while (!drp_den && n < 8) begin
            @(posedge clk); #1 n++;
        end
        chk("den_seen", drp_den, 1);
        chk("daddr", drp_daddr, {2'b00, ch});
    endtask

    task automatic give_drdy(input logic [11:0] v);
        @(posedge clk); #1 drp_do = {v, 4'h0}; drp_drdy = 1;
        @(posedge clk); #1 drp_drdy = 0; drp_do = 16'hDEAD;
    endtask

    task automatic sample(input logic [4:0] ch, input logic [11:0] v);
        pulse_eoc(ch);
        wait_den(ch);
        give_drdy(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        chk("rst_den", drp_den, 0);
        chk("rst_daddr", drp_daddr, 0);
        chk("rst_sel_value", sel_value, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_avg_stb", avg_stb, 0);
        chk("rst_avg_ch", avg_ch, 0);
        chk("rst_avg_value", avg_value, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_overrun", err_overrun, 0);
        reset_n = 1;
        idle(2);
        // lane 0: four full-scale samples
        repeat (3) sample(5'h16, 12'hFFC);
        exp_q.push_back('{2'd0, 12'hFFC});
        sample(5'h16, 12'hFFC);
        chk("stb_accum_cycle", avg_stb, 0);
        idle(1);
        chk("stb_two_after_drdy", avg_stb, 1);
        chk("ch_valid_lane0", ch_valid, 4'b0001);
        idle(2);
        // lane 1: truncating average of 1..4
        sample(5'h17, 12'h001);
        sample(5'h17, 12'h002);
        sample(5'h17, 12'h003);
        exp_q.push_back('{2'd1, 12'h002});
        sample(5'h17, 12'h004);
        idle(3);
        chk("ch_valid_lane01", ch_valid, 4'b0011);
        sel_ch = 1;
        chk("sel_latency_old", sel_value, 12'hFFC);
        idle(1);
        chk("sel_lane1", sel_value, 12'h002);
        // out-of-range channels above and below the window
        den_cnt = 0;
        pulse_eoc(5'h1A);
        repeat (6) begin
            if (drp_den) den_cnt++;
            idle(1);
        end
        pulse_eoc(5'h15);
        repeat (6) begin
            if (drp_den) den_cnt++;
            idle(1);
        end
        chk("out_of_range_den", den_cnt, 0);
        chk("out_of_range_to", err_timeout, 0);
        chk("out_of_range_ov", err_overrun, 0);
        // lane 2: DRDY withheld
        pulse_eoc(5'h18);
        wait_den(5'h18);
        idle(20);
        chk("timeout_early", err_timeout, 0);
        idle(15);
        chk("timeout_set", err_timeout, 1);
        chk("timeout_no_valid", ch_valid, 4'b0011);
        repeat (3) sample(5'h18, 12'h800);
        exp_q.push_back('{2'd2, 12'h800});
        sample(5'h18, 12'h800);
        idle(3);
        chk("timeout_still_set", err_timeout, 1);
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
        chk("timeout_cleared", err_timeout, 0);
        // lane 3: second EOC edge during WAIT
        pulse_eoc(5'h19);
        wait_den(5'h19);
        @(posedge clk); #1 eoc_in = 1;
        @(posedge clk); #1 eoc_in = 0; drp_do = {12'h010, 4'h0}; drp_drdy = 1;
        @(posedge clk); #1 drp_drdy = 0;
        idle(2);
        chk("overrun_set", err_overrun, 1);
        sample(5'h19, 12'h020);
        sample(5'h19, 12'h030);
        exp_q.push_back('{2'd3, 12'h028});
        sample(5'h19, 12'h040);
        idle(3);
        chk("ch_valid_all", ch_valid, 4'b1111);
        sel_ch = 3;
        idle(1);
        chk("sel_lane3", sel_value, 12'h028);
        // reset in WAIT, then a stale DRDY
        pulse_eoc(5'h16);
        wait_den(5'h16);
        @(posedge clk); #1 reset_n = 0;
        @(posedge clk); #1;
        chk("midrst_ch_valid", ch_valid, 0);
        chk("midrst_overrun", err_overrun, 0);
        chk("midrst_sel", sel_value, 0);
        reset_n = 1;
        give_drdy(12'hABC);
        idle(3);
        sample(5'h16, 12'h100);
        sample(5'h16, 12'h200);
        sample(5'h16, 12'h300);
        exp_q.push_back('{2'd0, 12'h280});
        sample(5'h16, 12'h400);
        idle(4);
        chk("after_rst_valid", ch_valid, 4'b0001);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
